// File: rtl/pc_unit.sv
// pc_unit: program counter with jr/jump/branch select,
// registered flush, halt state and saturating fetch counter.
module pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             JR_control,
    input  logic [15:0]      jr_target,
    input  logic             jump,
    input  logic [11:0]      jump_target,
    input  logic             branch,
    input  logic             zero,
    input  logic [7:0]       branch_offset,
    output logic [15:0]      pc,
    output logic [15:0]      pc_plus2,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [15:0]      pc_q;
    logic [15:0]      pc_d;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q;

    logic        active;
    logic        take_halt;
    logic        advance;
    logic        br_taken;
    logic        sel_jr;
    logic        sel_jmp;
    logic        sel_br;
    logic        sel_seq;
    logic        taken;
    logic [15:0] seq_pc;
    logic [15:0] jr_pc;
    logic [15:0] jmp_pc;
    logic [15:0] br_pc;
    logic [15:0] br_disp;

    assign seq_pc = pc_q + 16'd2;

    // Sampled controls: stall or halt freeze everything else.
    assign active    = (state_q == S_RUN) && !stall;
    assign take_halt = active && halt;
    assign advance   = active && !halt;
    assign br_taken  = branch && zero;

    // One-hot selects encode the jr > jump > branch > seq priority.
    assign sel_jr  = advance && JR_control;
    assign sel_jmp = advance && !JR_control && jump;
    assign sel_br  = advance && !JR_control && !jump && br_taken;
    assign sel_seq = advance && !JR_control && !jump && !br_taken;
    assign taken   = sel_jr || sel_jmp || sel_br;

    // Candidate targets; all keep bit 0 cleared.
    assign jr_pc   = jr_target & 16'hFFFE;
    assign jmp_pc  = {seq_pc[15:13], jump_target, 1'b0};
    assign br_disp = {{7{branch_offset[7]}}, branch_offset, 1'b0};
    assign br_pc   = seq_pc + br_disp;

    // Next-PC mux; holds when nothing is selected.
    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            sel_jr:  pc_d = jr_pc;
            sel_jmp: pc_d = jmp_pc;
            sel_br:  pc_d = br_pc;
            sel_seq: pc_d = seq_pc;
            default: pc_d = pc_q;
        endcase
    end

    // Next FSM state; HALTED is only left through reset.
    always_comb begin
        state_d = state_q;
        if (take_halt) begin
            state_d = S_HALTED;
        end
    end

    // PC, FSM and flush registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= {RESET_PC[15:1], 1'b0};
            state_q <= S_RUN;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            flush_q <= taken;
        end
    end

    // Saturating count of PC advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (advance && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign pc          = pc_q;
    assign pc_plus2    = seq_pc;
    assign flush       = flush_q;
    assign halted      = (state_q == S_HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit, plus a second
// instance with a 2-bit counter to reach saturation.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        JR_control;
    logic [15:0] jr_target;
    logic        jump;
    logic [11:0] jump_target;
    logic        branch;
    logic        zero;
    logic [7:0]  branch_offset;

    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        flush;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] s_pc;
    logic [15:0] s_pc_plus2;
    logic        s_flush;
    logic        s_halted;
    logic [1:0]  s_fetch_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .JR_control(JR_control), .jr_target(jr_target),
        .jump(jump), .jump_target(jump_target),
        .branch(branch), .zero(zero),
        .branch_offset(branch_offset),
        .pc(pc), .pc_plus2(pc_plus2), .flush(flush),
        .halted(halted), .fetch_count(fetch_count)
    );

    pc_unit #(.RESET_PC(16'h0100), .CNT_W(2)) sat (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt),
        .JR_control(JR_control), .jr_target(jr_target),
        .jump(jump), .jump_target(jump_target),
        .branch(branch), .zero(zero),
        .branch_offset(branch_offset),
        .pc(s_pc), .pc_plus2(s_pc_plus2), .flush(s_flush),
        .halted(s_halted), .fetch_count(s_fetch_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; halt = 0; JR_control = 0;
        jump = 0; branch = 0; zero = 0;
    endtask

    task automatic st(input string tag,
                      input logic [15:0] e_pc,
                      input logic e_fl,
                      input logic e_h,
                      input logic [15:0] e_cnt);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".flush"}, 32'(flush), 32'(e_fl));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".cnt"}, 32'(fetch_count), 32'(e_cnt));
    endtask

    initial begin
        idle();
        jr_target = 16'h0; jump_target = 12'h0;
        branch_offset = 8'h0;

        reset = 1; jump = 1; halt = 1;
        step();
        st("reset", 16'h0000, 0, 0, 16'd0);
        chk("sat_reset_pc", 32'(s_pc), 32'h0100);
        chk("reset_pc_plus2", 32'(pc_plus2), 32'h0002);

        idle();
        step(); st("idle1", 16'h0002, 0, 0, 16'd1);
        step(); st("idle2", 16'h0004, 0, 0, 16'd2);
        step(); st("idle3", 16'h0006, 0, 0, 16'd3);

        JR_control = 1; jr_target = 16'h0011;
        step(); st("jr_0010", 16'h0010, 1, 0, 16'd4);

        jump = 1; jr_target = 16'h1235; jump_target = 12'hABC;
        step(); st("jr_over_jump", 16'h1234, 1, 0, 16'd5);

        idle();
        step(); st("after_jr", 16'h1236, 0, 0, 16'd6);

        jump = 1; jump_target = 12'h010;
        step(); st("jump_0020", 16'h0020, 1, 0, 16'd7);

        idle(); branch = 1; zero = 1; branch_offset = 8'hFE;
        step(); st("br_back", 16'h001E, 1, 0, 16'd8);

        idle();
        step(); st("to_0020", 16'h0020, 0, 0, 16'd9);

        branch = 1; zero = 0; branch_offset = 8'hFE;
        step(); st("br_not_taken", 16'h0022, 0, 0, 16'd10);

        zero = 1; branch_offset = 8'h7F;
        step(); st("br_fwd", 16'h0122, 1, 0, 16'd11);

        idle(); JR_control = 1; jr_target = 16'hE100;
        step(); st("jr_e100", 16'hE100, 1, 0, 16'd12);

        idle(); jump = 1; jump_target = 12'h005;
        step(); st("jump_region", 16'hE00A, 1, 0, 16'd13);

        idle(); JR_control = 1; jr_target = 16'hFFFE;
        step(); st("jr_fffe", 16'hFFFE, 1, 0, 16'd14);
        chk("wrap_pc_plus2", 32'(pc_plus2), 32'h0000);

        idle();
        step(); st("wrap", 16'h0000, 0, 0, 16'd15);

        jump = 1; jump_target = 12'h020;
        step(); st("jump_0040", 16'h0040, 1, 0, 16'd16);

        stall = 1; jump_target = 12'h123;
        step(); st("stall1", 16'h0040, 0, 0, 16'd16);
        halt = 1; branch = 1; zero = 1;
        step(); st("stall2", 16'h0040, 0, 0, 16'd16);

        idle(); halt = 1; jump = 1;
        step(); st("halt", 16'h0040, 0, 1, 16'd16);

        halt = 0; JR_control = 1; jr_target = 16'h4444;
        for (int i = 0; i < 5; i++) begin
            step(); st("halted", 16'h0040, 0, 1, 16'd16);
        end

        reset = 1; stall = 1;
        step(); st("reset_halted", 16'h0000, 0, 0, 16'd0);
        chk("sat_reset_cnt", 32'(s_fetch_count), 32'd0);

        idle();
        for (int i = 0; i < 5; i++) step();
        st("post_reset", 16'h000A, 0, 0, 16'd5);
        chk("sat_pc", 32'(s_pc), 32'h010A);
        chk("sat_cnt", 32'(s_fetch_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` is the single clock, and `reset` is synchronous and active-high.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `CNT_W`, 16, width of the fetch counter.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- `clk`, input, 1, rising-edge clock.
- `reset`, input, 1, synchronous active-high reset.
- `stall`, input, 1, hold PC this cycle.
- `halt`, input, 1, halt instruction decoded.
- `JR_control`, input, 1, jump-register select from jr_control.
- `jr_target`, input, 16, register-file value for jr.
- `jump`, input, 1, absolute jump decoded.
- `jump_target`, input, 12, instruction immediate for jump.
- `branch`, input, 1, conditional branch decoded.
- `zero`, input, 1, ALU zero flag.
- `branch_offset`, input, 8, signed word offset.
- `pc`, output, 16, current instruction address.
- `pc_plus2`, output, 16, pc+2, used as the link value.
- `flush`, output, 1, discard the fetched instruction.
- `halted`, output, 1, the block is in the HALTED state.
- `fetch_count`, output, CNT_W, number of PC advances.

Function
REQ-004 The block SHALL implement a two-state FSM with states RUN and HALTED.
REQ-005 In RUN, `halt`=1 with `stall`=0 SHALL move the FSM to HALTED at the next edge, with `pc` unchanged.
REQ-006 HALTED SHALL be left only via `reset`.
REQ-007 In HALTED, `pc`, `flush`=0 and `fetch_count` SHALL be frozen regardless of other inputs.
REQ-008 `pc_plus2` SHALL be combinational `pc`+16'd2, modulo 2^16.
REQ-009 In RUN with `stall`=0, the next `pc` SHALL be selected by strict priority:
- `halt`: hold.
- `JR_control`: `{jr_target[15:1],1'b0}`.
- `jump`: `{pc_plus2[15:13], jump_target, 1'b0}`.
- `branch & zero`: `pc_plus2` + (sign-extended `branch_offset` << 1).
- Otherwise: `pc_plus2`.

REQ-010 All PC arithmetic SHALL wrap modulo 2^16 with no overflow indication; for example, 16'hFFFE advances to 16'h0000.
REQ-011 `stall`=1 in RUN SHALL hold `pc`, ignore every transfer input, leave `flush` at 0 and hold `fetch_count`.
REQ-012 A taken transfer (`JR_control`, `jump`, or `branch & zero`) accepted at an edge SHALL drive `flush`=1 for exactly the following cycle.
- A `branch` with `zero`=0 SHALL NOT assert `flush`.

REQ-013 `flush` SHALL be a registered output.
REQ-014 When taken transfers are accepted on consecutive edges, `flush` SHALL stay 1 for each following cycle.
REQ-015 `fetch_count` SHALL increment by 1 on every edge where `pc` is updated in RUN (not held), and saturate at all-ones.
REQ-016 `pc` SHALL always have bit 0 equal to 0.
REQ-017 `pc` SHALL change only at the rising edge of `clk`; all transfer inputs are sampled at that edge.
REQ-018 The block SHALL have one-cycle latency from inputs to `pc`.

Reset
REQ-019 `reset`=1 at an edge SHALL set: `pc`=`RESET_PC`, FSM=RUN, `flush`=0, `fetch_count`=0, `halted`=0.
REQ-020 `reset` SHALL have priority over `stall`, `halt` and every transfer input, including when asserted mid-halt or mid-stall.
REQ-021 `halted` SHALL be 1 exactly when the FSM is in HALTED.

Verification
REQ-022 Reset, then 3 idle cycles -> `pc` = 0, 2, 4, 6; `fetch_count`=3; `flush`=0 throughout.
REQ-023 `pc`=16'h0010 with `JR_control`=1, `jump`=1, `jr_target`=16'h1235 -> `pc`=16'h1234, `flush`=1 for one cycle, then 16'h1236.
REQ-024 `pc`=16'h0020, `branch`=1, `zero`=1, `branch_offset`=8'hFE -> `pc`=16'h001E.
REQ-025 The same branch with `zero`=0 -> `pc`=16'h0022 and `flush`=0.
REQ-026 `pc`=16'hFFFE idle -> `pc`=16'h0000.
REQ-027 `stall`=1 held for 2 cycles with `jump`=1 -> `pc` and `fetch_count` unchanged, `flush`=0.
REQ-028 `halt`=1 at `pc`=16'h0040 -> `halted`=1 and `pc` stays 16'h0040 for 5 cycles despite `jump`=1; `reset`=1 -> `pc`=0, `halted`=0.
